// File: rtl/traffic_phase_sched_pkg.sv
// Shared definitions for the intersection phase scheduler: state codes,
// lamp encodings and default phase durations.
package traffic_phase_sched_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_MG     = 3'd1,
      S_MY     = 3'd2,
      S_SG     = 3'd3,
      S_SY     = 3'd4,
      S_HOLD_A = 3'd5,
      S_HOLD_B = 3'd6
   } state_t;

   // One road's lamp vector, ordered {r,y,g}.
   localparam logic [2:0] LAMP_R = 3'b100;
   localparam logic [2:0] LAMP_Y = 3'b010;
   localparam logic [2:0] LAMP_G = 3'b001;

   localparam int G1_T_DEF  = 30;
   localparam int G2_T_DEF  = 25;
   localparam int Y_T_DEF   = 5;
   localparam int PED_T_DEF = 10;
   localparam int CW_DEF    = 8;

   // Returns {main{r,y,g}, side{r,y,g}} for a state.
   function automatic logic [5:0] lamps_of(state_t s);
      case (s)
         S_MG, S_HOLD_B: lamps_of = {LAMP_G, LAMP_R};
         S_MY:           lamps_of = {LAMP_Y, LAMP_R};
         S_SG, S_HOLD_A: lamps_of = {LAMP_R, LAMP_G};
         S_SY:           lamps_of = {LAMP_R, LAMP_Y};
         default:        lamps_of = {LAMP_R, LAMP_R};
      endcase
   endfunction

   function automatic logic is_blank(state_t s);
      return (s == S_IDLE) || (s == S_HOLD_A) || (s == S_HOLD_B);
   endfunction

endpackage

// File: rtl/traffic_phase_sched_phase_timer.sv
// Seconds-remaining down counter: load has priority, otherwise counts down on
// tick unless frozen; never wraps below zero.
module phase_timer #(
   parameter int CW = 8
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   input  logic          tick,
   input  logic          freeze,
   output logic [CW-1:0] count,
   output logic          expire
);

   logic [CW-1:0] count_reg;

   always_ff @(posedge clk or posedge clr) begin
      if (clr)
         count_reg <= '0;
      else if (load)
         count_reg <= load_val;
      else if (tick && !freeze && (count_reg != '0))
         count_reg <= count_reg - 1'b1;
   end

   assign count  = count_reg;
   assign expire = (count_reg == CW'(1));

endmodule

// File: rtl/traffic_phase_sched.sv
// Two-road intersection phase scheduler: sequences green/yellow/red phases,
// arbitrates stop/pause/pedestrian requests and drives lamps and countdowns.
module traffic_phase_sched
   import traffic_phase_sched_pkg::*;
#(
   parameter int G1_T  = G1_T_DEF,
   parameter int G2_T  = G2_T_DEF,
   parameter int Y_T   = Y_T_DEF,
   parameter int PED_T = PED_T_DEF,
   parameter int CW    = CW_DEF
) (
   input  logic          clk,
   input  logic          clr,
   input  logic          tick,
   input  logic          start,
   input  logic          stopa,
   input  logic          stopb,
   input  logic          pause,
   input  logic          ped_req,
   output logic          r1,
   output logic          y1,
   output logic          g1,
   output logic          r2,
   output logic          y2,
   output logic          g2,
   output logic [CW-1:0] cnt1,
   output logic [CW-1:0] cnt2,
   output logic          blank,
   output logic [2:0]    phase
);

   localparam logic [CW-1:0] K_G1   = CW'(G1_T);
   localparam logic [CW-1:0] K_G1Y  = CW'(G1_T + Y_T);
   localparam logic [CW-1:0] K_G2   = CW'(G2_T);
   localparam logic [CW-1:0] K_G2Y  = CW'(G2_T + Y_T);
   localparam logic [CW-1:0] K_Y    = CW'(Y_T);
   localparam logic [CW-1:0] K_PED  = CW'(PED_T);
   localparam logic [CW-1:0] K_PEDY = CW'(PED_T + Y_T);

   state_t        state_reg, state_next;
   logic          ped_reg, ped_next;
   logic [5:0]    lamps_reg;
   logic          blank_reg;

   // Index 0 drives cnt1 (main road), index 1 drives cnt2 (side road).
   logic [1:0]    load_v, run_v, exp_v;
   logic [CW-1:0] val_v [2];
   logic [CW-1:0] cnt_v [2];

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_timer
         phase_timer #(.CW(CW)) u_timer (
            .clk      (clk),
            .clr      (clr),
            .load     (load_v[gi]),
            .load_val (val_v[gi]),
            .tick     (tick),
            .freeze   (~run_v[gi]),
            .count    (cnt_v[gi]),
            .expire   (exp_v[gi])
         );
      end
   endgenerate

   always_comb begin
      state_next = state_reg;
      load_v     = 2'b00;
      run_v      = 2'b00;
      val_v[0]   = '0;
      val_v[1]   = '0;
      ped_next   = ped_reg | (ped_req && (state_reg != S_IDLE));

      case (state_reg)
         S_IDLE: begin
            if (stopa)
               state_next = S_HOLD_A;
            else if (stopb)
               state_next = S_HOLD_B;
            else if (!pause && start) begin
               state_next = S_MG;
               load_v     = 2'b11;
               val_v[0]   = K_G1;
               val_v[1]   = K_G1Y;
            end
         end
         S_MG: begin
            if (stopa) begin
               state_next = S_MY;
               load_v     = 2'b11;
               val_v[0]   = K_Y;
               val_v[1]   = K_Y;
            end else if (stopb)
               state_next = S_HOLD_B;
            else if (!pause && tick) begin
               if (exp_v[0]) begin
                  state_next = S_MY;
                  load_v[0]  = 1'b1;
                  val_v[0]   = K_Y;
                  run_v[1]   = 1'b1;
               end else if ((ped_reg || ped_req) && (cnt_v[0] > K_PED)) begin
                  load_v   = 2'b11;
                  val_v[0] = K_PED;
                  val_v[1] = K_PEDY;
               end else
                  run_v = 2'b11;
            end
         end
         S_MY: begin
            // A stopa yellow keeps timing through pause so the hold is reached.
            if (stopb && !stopa)
               state_next = S_HOLD_B;
            else if ((!pause || stopa) && tick) begin
               if (exp_v[0]) begin
                  if (stopa)
                     state_next = S_HOLD_A;
                  else if (start) begin
                     state_next = S_SG;
                     load_v     = 2'b11;
                     val_v[0]   = K_G2Y;
                     val_v[1]   = K_G2;
                  end else
                     state_next = S_IDLE;
               end else
                  run_v = 2'b11;
            end
         end
         S_SG: begin
            if (stopa)
               state_next = S_HOLD_A;
            else if (stopb) begin
               state_next = S_SY;
               load_v     = 2'b11;
               val_v[0]   = K_Y;
               val_v[1]   = K_Y;
            end else if (!pause && tick) begin
               if (exp_v[1]) begin
                  state_next = S_SY;
                  load_v[1]  = 1'b1;
                  val_v[1]   = K_Y;
                  run_v[0]   = 1'b1;
               end else
                  run_v = 2'b11;
            end
         end
         S_SY: begin
            if (stopa)
               state_next = S_HOLD_A;
            else if ((!pause || stopb) && tick) begin
               if (exp_v[1]) begin
                  if (stopb)
                     state_next = S_HOLD_B;
                  else if (start) begin
                     state_next = S_MG;
                     load_v     = 2'b11;
                     val_v[0]   = K_G1;
                     val_v[1]   = K_G1Y;
                  end else
                     state_next = S_IDLE;
               end else
                  run_v = 2'b11;
            end
         end
         S_HOLD_A: begin
            if (!stopa) begin
               state_next = S_SY;
               load_v     = 2'b11;
               val_v[0]   = K_Y;
               val_v[1]   = K_Y;
            end
         end
         S_HOLD_B: begin
            // Main road is green here, so a new stopa must also go via yellow.
            if (stopa || !stopb) begin
               state_next = S_MY;
               load_v     = 2'b11;
               val_v[0]   = K_Y;
               val_v[1]   = K_Y;
            end
         end
         default: state_next = S_IDLE;
      endcase

      // Display is blanked in these states, so the counts are parked at zero.
      if (is_blank(state_next)) begin
         load_v   = 2'b11;
         run_v    = 2'b00;
         val_v[0] = '0;
         val_v[1] = '0;
      end

      if ((state_next == S_SG) && (state_reg != S_SG))
         ped_next = 1'b0;
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_reg <= S_IDLE;
         ped_reg   <= 1'b0;
         lamps_reg <= {LAMP_R, LAMP_R};
         blank_reg <= 1'b1;
      end else begin
         state_reg <= state_next;
         ped_reg   <= ped_next;
         lamps_reg <= lamps_of(state_next);
         blank_reg <= is_blank(state_next);
      end
   end

   assign {r1, y1, g1, r2, y2, g2} = lamps_reg;
   assign cnt1  = cnt_v[0];
   assign cnt2  = cnt_v[1];
   assign blank = blank_reg;
   assign phase = state_reg;

endmodule

// File: tb/tb_traffic_phase_sched.sv
// Scoreboard bench for traffic_phase_sched: directed scenarios push expected
// outputs; a negedge monitor pops and compares them.
module tb_traffic_phase_sched;

   localparam logic [2:0] P_IDLE = 3'd0, P_MG = 3'd1, P_MY = 3'd2, P_SG = 3'd3,
                          P_SY = 3'd4, P_HA = 3'd5, P_HB = 3'd6;

   logic       clk = 1'b0;
   logic       clr = 1'b0, tick = 1'b0, start = 1'b0, stopa = 1'b0;
   logic       stopb = 1'b0, pause = 1'b0, ped_req = 1'b0;
   logic       r1, y1, g1, r2, y2, g2, blank;
   logic [7:0] cnt1, cnt2;
   logic [2:0] phase;

   always #5 clk = ~clk;

   traffic_phase_sched dut (
      .clk(clk), .clr(clr), .tick(tick), .start(start), .stopa(stopa),
      .stopb(stopb), .pause(pause), .ped_req(ped_req),
      .r1(r1), .y1(y1), .g1(g1), .r2(r2), .y2(y2), .g2(g2),
      .cnt1(cnt1), .cnt2(cnt2), .blank(blank), .phase(phase)
   );

   typedef struct {
      string      name;
      logic [2:0] ph;
      logic [7:0] c1;
      logic [7:0] c2;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Lamps {r1,y1,g1,r2,y2,g2} each state must show.
   function automatic logic [5:0] lamps_for(logic [2:0] p);
      case (p)
         P_MG, P_HB: return 6'b001_100;
         P_MY:       return 6'b010_100;
         P_SG, P_HA: return 6'b100_001;
         P_SY:       return 6'b100_010;
         default:    return 6'b100_100;
      endcase
   endfunction

   function automatic logic blank_for(logic [2:0] p);
      return (p == P_IDLE) || (p == P_HA) || (p == P_HB);
   endfunction

   exp_t        mon_e;
   logic [25:0] mon_got, mon_want;

   initial begin
      forever begin
         @(negedge clk);
         while (sb_q.size() > 0) begin
            mon_e    = sb_q.pop_front();
            mon_got  = {phase, r1, y1, g1, r2, y2, g2, cnt1, cnt2, blank};
            mon_want = {mon_e.ph, lamps_for(mon_e.ph), mon_e.c1, mon_e.c2, blank_for(mon_e.ph)};
            n_checks++;
            if (mon_got !== mon_want) begin
               n_fail++;
               $display("FAIL %s: got phase=%0d lamps=%b cnt1=%0d cnt2=%0d blank=%b, want phase=%0d lamps=%b cnt1=%0d cnt2=%0d blank=%b",
                        mon_e.name, phase, {r1, y1, g1, r2, y2, g2}, cnt1, cnt2, blank,
                        mon_e.ph, lamps_for(mon_e.ph), mon_e.c1, mon_e.c2, blank_for(mon_e.ph));
            end else
               $display("ok   %s: phase=%0d cnt1=%0d cnt2=%0d", mon_e.name, phase, cnt1, cnt2);
         end
      end
   end

   task automatic expect_now(string n, logic [2:0] p, int c1, int c2);
      exp_t e;
      e.name = n;
      e.ph   = p;
      e.c1   = 8'(c1);
      e.c2   = 8'(c2);
      sb_q.push_back(e);
   endtask

   // All stimulus runs at posedge+1; expectations are checked at the next negedge.
   task automatic cyc(string n, logic [2:0] p, int c1, int c2);
      @(posedge clk);
      #1;
      expect_now(n, p, c1, c2);
   endtask

   task automatic idle_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_cyc(string n, logic [2:0] p, int c1, int c2);
      tick = 1'b1;
      cyc(n, p, c1, c2);
      tick = 1'b0;
      idle_cyc();
   endtask

   task automatic tick_run(string n, logic [2:0] p, int c1, int c2, int cnt);
      for (int k = 1; k <= cnt; k++)
         tick_cyc(n, p, c1 - k, c2 - k);
   endtask

   // clr is raised between clock edges so its effect must be asynchronous.
   task automatic do_reset(string n);
      #2;
      clr = 1'b1;
      start = 1'b0; stopa = 1'b0; stopb = 1'b0; pause = 1'b0; ped_req = 1'b0; tick = 1'b0;
      #1;
      expect_now(n, P_IDLE, 0, 0);
      @(posedge clk);
      #1;
      clr = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required normal completion");
      $fatal(1, "watchdog");
   end

   initial begin
      @(posedge clk);
      #1;

      // Normal cycle for 80 ticks.
      do_reset("reset");
      start = 1'b1;
      cyc("idle_to_mg", P_MG, 30, 35);
      tick_run("mg", P_MG, 30, 35, 29);
      tick_cyc("mg_to_my", P_MY, 5, 5);
      tick_run("my", P_MY, 5, 5, 4);
      tick_cyc("my_to_sg", P_SG, 30, 25);
      tick_run("sg", P_SG, 30, 25, 24);
      tick_cyc("sg_to_sy", P_SY, 5, 5);
      tick_run("sy", P_SY, 5, 5, 4);
      tick_cyc("sy_to_mg", P_MG, 30, 35);
      tick_run("mg2", P_MG, 30, 35, 15);

      // stopa during main green.
      do_reset("reset2");
      start = 1'b1;
      cyc("idle_to_mg", P_MG, 30, 35);
      tick_run("mg", P_MG, 30, 35, 10);
      stopa = 1'b1;
      cyc("stopa_mg", P_MY, 5, 5);
      tick_run("stopa_my", P_MY, 5, 5, 4);
      tick_cyc("my_to_hold_a", P_HA, 0, 0);
      tick_cyc("hold_a_tick", P_HA, 0, 0);
      stopa = 1'b0;
      cyc("release_a", P_SY, 5, 5);
      tick_run("rel_sy", P_SY, 5, 5, 4);
      tick_cyc("rel_sy_to_mg", P_MG, 30, 35);

      // stopa and stopb together from IDLE, then stopb on side green.
      do_reset("reset3");
      start = 1'b1;
      stopa = 1'b1;
      stopb = 1'b1;
      cyc("both_idle", P_HA, 0, 0);
      cyc("both_hold", P_HA, 0, 0);
      stopa = 1'b0;
      cyc("drop_a", P_SY, 5, 5);
      tick_run("drop_a_sy", P_SY, 5, 5, 4);
      tick_cyc("sy_to_hold_b", P_HB, 0, 0);
      tick_cyc("hold_b_tick", P_HB, 0, 0);
      stopb = 1'b0;
      cyc("release_b", P_MY, 5, 5);
      tick_run("rel_my", P_MY, 5, 5, 4);
      tick_cyc("rel_my_to_sg", P_SG, 30, 25);
      tick_run("sg", P_SG, 30, 25, 3);
      stopb = 1'b1;
      cyc("stopb_sg", P_SY, 5, 5);
      tick_run("stopb_sy", P_SY, 5, 5, 4);
      tick_cyc("stopb_to_hold_b", P_HB, 0, 0);
      stopb = 1'b0;

      // Pedestrian request shortening, late request, latch clearing.
      do_reset("reset4");
      start = 1'b1;
      cyc("idle_to_mg", P_MG, 30, 35);
      tick_run("mg", P_MG, 30, 35, 5);
      ped_req = 1'b1;
      cyc("ped_latch", P_MG, 25, 30);
      ped_req = 1'b0;
      tick_cyc("ped_apply", P_MG, 10, 15);
      tick_run("ped_mg", P_MG, 10, 15, 2);
      ped_req = 1'b1;
      cyc("ped_late", P_MG, 8, 13);
      ped_req = 1'b0;
      tick_cyc("ped_late_tick", P_MG, 7, 12);
      tick_run("ped_mg2", P_MG, 7, 12, 6);
      tick_cyc("ped_to_my", P_MY, 5, 5);
      tick_run("ped_my", P_MY, 5, 5, 4);
      tick_cyc("ped_to_sg", P_SG, 30, 25);
      tick_run("ped_sg", P_SG, 30, 25, 24);
      tick_cyc("ped_to_sy", P_SY, 5, 5);
      tick_run("ped_sy", P_SY, 5, 5, 4);
      tick_cyc("ped_to_mg", P_MG, 30, 35);
      tick_cyc("ped_cleared", P_MG, 29, 34);

      // Pause freezes counts; then clr in the middle of side green.
      do_reset("reset5");
      start = 1'b1;
      cyc("idle_to_mg", P_MG, 30, 35);
      tick_run("mg", P_MG, 30, 35, 18);
      pause = 1'b1;
      for (int k = 0; k < 10; k++)
         tick_cyc("paused", P_MG, 12, 17);
      pause = 1'b0;
      tick_cyc("unpause", P_MG, 11, 16);
      tick_run("mg_after", P_MG, 11, 16, 10);
      tick_cyc("mg_to_my", P_MY, 5, 5);
      tick_run("my", P_MY, 5, 5, 4);
      tick_cyc("my_to_sg", P_SG, 30, 25);
      tick_run("sg", P_SG, 30, 25, 3);
      do_reset("clr_mid_sg");

      // start dropped during main green: finish MY, then IDLE.
      start = 1'b1;
      cyc("idle_to_mg", P_MG, 30, 35);
      start = 1'b0;
      tick_run("mg_nostart", P_MG, 30, 35, 29);
      tick_cyc("mg_to_my", P_MY, 5, 5);
      tick_run("my_nostart", P_MY, 5, 5, 4);
      tick_cyc("my_to_idle", P_IDLE, 0, 0);
      cyc("idle_stays", P_IDLE, 0, 0);

      idle_cyc();
      @(negedge clk);
      #1;
      if (sb_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: %0d expectations left unchecked, required 0", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
